// File: rtl/lsu_riscv_pkg.sv
// rtl/lsu_riscv_pkg.sv - shared LDST size codes, FSM state type and defaults for the LSU
package lsu_riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    localparam int LSU_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_e;

    // Unsigned sizes only make sense on loads; everything else must be naturally aligned.
    function automatic logic ldst_ok(input logic we, input logic [2:0] size, input logic [1:0] offset);
        logic ok;
        case (size)
            LDST_B:  ok = 1'b1;
            LDST_BU: ok = !we;
            LDST_H:  ok = !offset[0];
            LDST_HU: ok = !we && !offset[0];
            LDST_W:  ok = (offset == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - byte-enable/store-data replication and load extraction
module lsu_data_align
    import lsu_riscv_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;
    logic [15:0] half;

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (size)
            LDST_B, LDST_BU: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            LDST_H, LDST_HU: begin
                be    = 4'b0011 << {offset[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        shifted   = rdata >> {offset, 3'b000};
        half      = offset[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (size)
            LDST_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            LDST_BU: load_data = {24'h0, shifted[7:0]};
            LDST_H:  load_data = {{16{half[15]}}, half};
            LDST_HU: load_data = {16'h0, half};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_riscv.sv
// rtl/lsu_riscv.sv - single-outstanding load/store unit bridging the core to a req/gnt/rvalid bus
module lsu_riscv
    import lsu_riscv_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic        err_q;
    logic [31:0] cnt_q;
    logic [31:0] load_q;

    logic        access_ok;
    logic        timeout_hit;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load_data;

    assign access_ok   = ldst_ok(lsu_we_i, lsu_size_i, lsu_addr_i[1:0]);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));

    lsu_data_align u_align (
        .size       (size_q),
        .offset     (addr_q[1:0]),
        .store_data (sdata_q),
        .rdata      (data_rdata_i),
        .be         (be),
        .wdata      (wdata),
        .load_data  (load_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (lsu_req_i) state_d = access_ok ? ST_REQ : ST_DONE;
            ST_REQ: begin
                if (timeout_hit)     state_d = ST_DONE;
                else if (data_gnt_i) state_d = ST_WAIT;
            end
            // A response landing on the timeout cycle still wins.
            ST_WAIT: if (data_rvalid_i || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= 32'h0;
            sdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= 32'h0;
            load_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (lsu_req_i) begin
                        err_q <= !access_ok;
                        cnt_q <= 32'h0;
                        if (access_ok) begin
                            we_q    <= lsu_we_i;
                            size_q  <= lsu_size_i;
                            addr_q  <= lsu_addr_i;
                            sdata_q <= lsu_data_i;
                        end
                    end
                end
                ST_REQ: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (timeout_hit) err_q <= 1'b1;
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (data_rvalid_i) begin
                        if (!we_q) load_q <= load_data;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus-side payload is only presented while requesting so idle/reset outputs read as zero.
    assign data_req_o   = (state_q == ST_REQ);
    assign data_we_o    = data_req_o & we_q;
    assign data_be_o    = data_req_o ? be : 4'b0000;
    assign data_addr_o  = data_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
    assign data_wdata_o = data_req_o ? wdata : 32'h0;

    assign lsu_stall_req_o = arstn_i & lsu_req_i & (state_q != ST_DONE);
    assign lsu_err_o       = (state_q == ST_DONE) & err_q;
    assign lsu_data_o      = load_q;

endmodule

// File: tb/tb_lsu_riscv.sv
// tb/tb_lsu_riscv.sv - directed self-checking bench for lsu_riscv
module tb_lsu_riscv;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        lsu_req = 1'b0;
    logic        lsu_we = 1'b0;
    logic [2:0]  lsu_size = 3'd0;
    logic [31:0] lsu_addr = 32'h0;
    logic [31:0] lsu_wd = 32'h0;
    logic [31:0] lsu_rd;
    logic        stall;
    logic        err;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;

    int checks = 0;
    int failures = 0;

    logic [3:0]  obs_be;
    logic [31:0] obs_addr;
    logic [31:0] obs_wdata;
    logic        obs_we;
    logic        obs_req;
    logic        obs_stall_wait;
    logic        obs_stall_done;
    logic        obs_err_done;
    int          n_req;
    int          n_err;
    logic        req_at_err;

    lsu_riscv #(.TIMEOUT(4)) dut (
        .clk_i           (clk),
        .arstn_i         (arstn),
        .lsu_req_i       (lsu_req),
        .lsu_we_i        (lsu_we),
        .lsu_size_i      (lsu_size),
        .lsu_addr_i      (lsu_addr),
        .lsu_data_i      (lsu_wd),
        .lsu_data_o      (lsu_rd),
        .lsu_stall_req_o (stall),
        .lsu_err_o       (err),
        .data_req_o      (data_req),
        .data_we_o       (data_we),
        .data_be_o       (data_be),
        .data_addr_o     (data_addr),
        .data_wdata_o    (data_wdata),
        .data_gnt_i      (gnt),
        .data_rvalid_i   (rvalid),
        .data_rdata_i    (rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Minimum-latency access: req cycle 0, gnt cycle 1, rvalid cycle 2, DONE cycle 3.
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd);
        @(posedge clk); #1;
        lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_wd = wd;
        @(posedge clk); #1;
        obs_req = data_req; obs_be = data_be; obs_addr = data_addr;
        obs_wdata = data_wdata; obs_we = data_we;
        gnt = 1'b1;
        @(posedge clk); #1;
        gnt = 1'b0; rvalid = 1'b1; rdata = rd;
        obs_stall_wait = stall;
        @(posedge clk); #1;
        rvalid = 1'b0;
        obs_stall_done = stall; obs_err_done = err;
        lsu_req = 1'b0;
    endtask

    initial begin
        lsu_req = 1'b1;
        #2;
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_data", lsu_rd, 32'h0);
        chk("reset_req", 32'(data_req), 32'h0);
        chk("reset_err", 32'(err), 32'h0);
        lsu_req = 1'b0;
        @(posedge clk); #1;
        arstn = 1'b1;

        access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF);
        chk("lw_req", 32'(obs_req), 32'h1);
        chk("lw_be", 32'(obs_be), 32'hF);
        chk("lw_addr", obs_addr, 32'h100);
        chk("lw_stall_wait", 32'(obs_stall_wait), 32'h1);
        chk("lw_stall_done", 32'(obs_stall_done), 32'h0);
        chk("lw_data", lsu_rd, 32'hDEAD_BEEF);
        chk("lw_err", 32'(obs_err_done), 32'h0);

        access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_FFFF);
        chk("lb_be", 32'(obs_be), 32'h8);
        chk("lb_addr", obs_addr, 32'h100);
        chk("lb_data", lsu_rd, 32'hFFFF_FF80);

        access(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_FFFF);
        chk("lbu_data", lsu_rd, 32'h0000_0080);

        access(1'b0, 3'd1, 32'h102, 32'h0, 32'h8001_0000);
        chk("lh_be", 32'(obs_be), 32'hC);
        chk("lh_data", lsu_rd, 32'hFFFF_8001);

        access(1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 32'h7777_7777);
        chk("sh_addr", obs_addr, 32'h200);
        chk("sh_be", 32'(obs_be), 32'hC);
        chk("sh_wdata", obs_wdata, 32'hABCD_ABCD);
        chk("sh_we", 32'(obs_we), 32'h1);
        chk("sh_keeps_data", lsu_rd, 32'hFFFF_8001);

        access(1'b1, 3'd0, 32'h301, 32'h0000_00A5, 32'h0);
        chk("sb_be", 32'(obs_be), 32'h2);
        chk("sb_wdata", obs_wdata, 32'hA5A5_A5A5);

        // Misaligned word load.
        @(posedge clk); #1;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h101;
        @(posedge clk); #1;
        chk("mis_err", 32'(err), 32'h1);
        chk("mis_stall", 32'(stall), 32'h0);
        chk("mis_noreq", 32'(data_req), 32'h0);
        lsu_req = 1'b0;
        @(posedge clk); #1;
        chk("mis_err_pulse", 32'(err), 32'h0);
        chk("mis_keeps_data", lsu_rd, 32'hFFFF_8001);

        // Store with unsigned-byte size is illegal.
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 3'd4; lsu_addr = 32'h100;
        @(posedge clk); #1;
        chk("ill_err", 32'(err), 32'h1);
        chk("ill_stall", 32'(stall), 32'h0);
        chk("ill_noreq", 32'(data_req), 32'h0);
        lsu_req = 1'b0;
        @(posedge clk); #1;
        chk("ill_err_pulse", 32'(err), 32'h0);

        // Core drops the request mid-access; the load still lands.
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd5; lsu_addr = 32'h106;
        @(posedge clk); #1;
        lsu_req = 1'b0; gnt = 1'b1;
        #1;
        chk("drop_req_active", 32'(data_req), 32'h1);
        chk("drop_stall", 32'(stall), 32'h0);
        @(posedge clk); #1;
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hF00D_1234;
        @(posedge clk); #1;
        rvalid = 1'b0;
        chk("drop_data", lsu_rd, 32'h0000_F00D);

        // Timeout: grant never comes.
        @(posedge clk); #1;
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 3'd2; lsu_addr = 32'h300; lsu_wd = 32'h1;
        n_req = 0; n_err = 0; req_at_err = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (data_req) n_req++;
            if (err) begin
                n_err++;
                req_at_err = data_req;
                lsu_req = 1'b0;
            end
        end
        chk("to_req_cycles", 32'(n_req), 32'd4);
        chk("to_err_pulses", 32'(n_err), 32'd1);
        chk("to_req_dropped", 32'(req_at_err), 32'h0);
        chk("to_idle_stall", 32'(stall), 32'h0);

        // Reset while waiting for the response, then a stale rvalid.
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h104;
        @(posedge clk); #1;
        gnt = 1'b1;
        @(posedge clk); #1;
        gnt = 1'b0;
        chk("rst_wait_stall", 32'(stall), 32'h1);
        arstn = 1'b0;
        #1;
        chk("rst_now_stall", 32'(stall), 32'h0);
        chk("rst_now_req", 32'(data_req), 32'h0);
        chk("rst_now_data", lsu_rd, 32'h0);
        chk("rst_now_err", 32'(err), 32'h0);
        @(posedge clk); #1;
        arstn = 1'b1; lsu_req = 1'b0;
        @(posedge clk); #1;
        rvalid = 1'b1; rdata = 32'h5555_5555;
        @(posedge clk); #1;
        rvalid = 1'b0;
        chk("late_rvalid_data", lsu_rd, 32'h0);
        chk("late_rvalid_err", 32'(err), 32'h0);
        chk("late_rvalid_req", 32'(data_req), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_riscv.md
LSU_RISCV -- requirements
Module: lsu_riscv

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning max cycles in REQ+WAIT before error abort; 0 disables timeout.
REQ-002 clk_i  in  1  single clock; all state on rising edge.
REQ-003 arstn_i  in  1  reset, asynchronous, active-low.
REQ-004 lsu_req_i  in  1  core memory request, held until lsu_stall_req_o low.
REQ-005 lsu_we_i  in  1  1 = store, 0 = load.
REQ-006 lsu_size_i  in  3  LDST size code (B=0, H=1, W=2, BU=4, HU=5).
REQ-007 lsu_addr_i  in  32  byte address.
REQ-008 lsu_data_i  in  32  store data, LSB-aligned.
REQ-009 lsu_data_o  out  32  load result, extended to 32 bits.
REQ-010 lsu_stall_req_o  out  1  core stall while access is in progress.
REQ-011 lsu_err_o  out  1  one-cycle pulse: misaligned, illegal size or timeout.
REQ-012 data_req_o  out  1  memory request; data_we_o out 1 write enable; data_be_o out 4 byte enables.
REQ-013 data_addr_o  out  32  word address {addr[31:2],2'b00}; data_wdata_o out 32 replicated store data.
REQ-014 data_gnt_i  in  1  request accepted; data_rvalid_i in 1 response valid; data_rdata_i in 32 read word.

Function
REQ-015 FSM states IDLE, REQ, WAIT, DONE; encoding free.
REQ-016 IDLE: lsu_req_i=1 with legal size and alignment -> latch we/size/addr/data, go REQ; illegal/misaligned -> go DONE with error flag, no memory access.
REQ-017 Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0. Illegal: size 3,6,7; size 4,5 on store.
REQ-018 REQ: data_req_o=1 with latched addr/we/be/wdata stable; data_gnt_i=1 -> WAIT.
REQ-019 WAIT: data_req_o=0; data_rvalid_i=1 -> capture (load only) into lsu_data_o, go DONE; rvalid in same cycle as gnt is not accepted.
REQ-020 DONE: lsu_stall_req_o=0, lsu_err_o=error flag, then unconditionally IDLE.
REQ-021 lsu_stall_req_o = lsu_req_i AND state!=DONE (combinational).
REQ-022 Minimum latency: req cycle 0, gnt cycle 1, rvalid cycle 2 -> stall low cycle 3.
REQ-023 data_be_o: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<{addr[1],1'b0}; W 4'b1111; also driven on loads.
REQ-024 data_wdata_o: B {4{data[7:0]}}, H {2{data[15:0]}}, W data.
REQ-025 Load extract: byte at addr[1:0] / half at addr[1]; B,H sign-extend; BU,HU zero-extend; W unchanged.
REQ-026 lsu_data_o holds last load value until next load completes; stores and errors leave it unchanged.
REQ-027 Timeout counter counts cycles in REQ/WAIT; reaching TIMEOUT -> DONE with error, data_req_o dropped; rvalid arriving in IDLE/DONE ignored.
REQ-028 lsu_req_i dropped mid-access: access still completes to DONE; result written, stall follows lsu_req_i.

Reset
REQ-029 arstn_i low: state IDLE, counter 0, lsu_data_o 0, all outputs 0, effective immediately, including mid-access.
REQ-030 No pending response survives reset; rvalid seen in IDLE after reset ignored.

Structure
REQ-031 Shared package holds LDST size codes, FSM state typedef and default TIMEOUT constant.
REQ-032 One combinational sub-module lsu_data_align: be/wdata generation and load extraction.
REQ-033 Target 150-300 lines RTL; no latches, all sequential logic on clk_i/negedge arstn_i.

Verification
REQ-034 LW addr 0x100, gnt cycle 1, rvalid cycle 2 rdata 0xDEADBEEF -> stall low cycle 3, lsu_data_o=0xDEADBEEF, be=4'b1111.
REQ-035 LB addr 0x103, rdata 0x80FF_FFFF -> lsu_data_o=0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 SH addr 0x202 data 0x1234ABCD -> data_addr_o=0x200, be=4'b1100, wdata=0xABCDABCD, we=1.
REQ-037 LW addr 0x101 -> no data_req_o, lsu_err_o pulse cycle 1, stall low cycle 1; SB size 4 -> same.
REQ-038 TIMEOUT=4, gnt never -> data_req_o high 4 cycles, lsu_err_o pulse, state IDLE.
REQ-039 arstn_i low in WAIT, late rvalid after release -> all outputs 0, no capture, no err.
